registro_fifo_muestras: RTL

- Parametrised successor to the single enabled sample register.
- Buffers WIDTH-bit offset-binary samples in a DEPTH-entry FIFO and presents them through a registered output.
- The output resets to midscale.
- Sits between the sample producer (ADC/processing path) and the consumer (DAC/display path), absorbing rate jitter.
- Adds full/empty/count status and overflow/underflow flags.

---
 rtl/registro_pkg.sv | 32 +++
 rtl/registro_fifo_mem.sv | 37 +++
 rtl/registro_fifo_muestras.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/registro_pkg.sv
// ============================================================================
// Package     : registro_pkg
// Description : Shared constants and helpers for the sample FIFO register:
//               default sample width, pointer/count width helpers and the
//               midscale (offset-binary zero) value for a given width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package registro_pkg;

  // Default offset-binary sample width.
  localparam int DEFAULT_WIDTH = 12;

  // Pointer width for a DEPTH-entry array; kept at least one bit wide.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must be able to represent DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Offset-binary zero: only the MSB set (12'h800 at 12 bits).
  function automatic logic [31:0] MIDSCALE(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage : registro_pkg

`default_nettype wire

// File: rtl/registro_fifo_mem.sv
// ============================================================================
// Module      : registro_fifo_mem
// Description : Simple dual-port sample storage. One synchronous write port,
//               one asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registro_fifo_mem
  import registro_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store the pushed sample on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port is combinational so the head is visible before the pop edge.
  assign rdata = r_mem[raddr];

endmodule : registro_fifo_mem

`default_nettype wire

// File: rtl/registro_fifo_muestras.sv
// ============================================================================
// Module      : registro_fifo_muestras
// Description : DEPTH-entry FIFO of WIDTH-bit offset-binary samples with a
//               registered output that resets to midscale. Provides
//               full/empty/count status and one-cycle overflow, underflow
//               and dato_valid pulses.
// Options     : REGISTRO_FIFO_MIDSCALE_ON_UNDERFLOW_EN - when defined, a pop
//               on an empty FIFO reloads dato_out with RESET_VAL so a
//               starving consumer returns to midscale; otherwise dato_out
//               holds its last value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module registro_fifo_muestras
  import registro_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(MIDSCALE(WIDTH))
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         dato_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dato_out,
  output logic                     dato_valid,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dato_out;
  logic             r_dato_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_starve;
  logic [WIDTH-1:0] w_head;

  // Status is derived directly from the occupancy register.
  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);

  // A full FIFO still accepts a push when a pop frees the head slot on the
  // same edge. An empty FIFO never pops: there is no write-to-read bypass.
  assign w_push   = wr_en && (!w_full || rd_en);
  assign w_pop    = rd_en && !w_empty;
  assign w_drop   = wr_en && !w_push;
  assign w_starve = rd_en && w_empty;

  registro_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (dato_in),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Occupancy: up on push only, down on pop only, otherwise unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: loads the head on a pop; underflow handling is a
  // build-time choice between holding and returning to midscale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dato_out <= RESET_VAL;
    end else if (w_pop) begin
      r_dato_out <= w_head;
`ifdef REGISTRO_FIFO_MIDSCALE_ON_UNDERFLOW_EN
    end else if (w_starve) begin
      r_dato_out <= RESET_VAL;
`else
    end else begin
      r_dato_out <= r_dato_out;
`endif
    end
  end

  // Event pulses: each reflects only the edge just taken, never sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dato_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dato_valid <= w_pop;
      r_overflow   <= w_drop;
      r_underflow  <= w_starve;
    end
  end

  assign dato_out   = r_dato_out;
  assign dato_valid = r_dato_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule : registro_fifo_muestras

`default_nettype wire
